mnist_frame_driver: RTL and testbench

- Producer/consumer end of the mnist_mtncl gate-network interface.
- Accepts a valid/ready stream of grayscale pixels and binarises each one against a threshold.
- Assembles the bits into the 49-bit in_bits vector and presents it to the network between all-zero NULL spacers.
- Samples the 2-bit out_bits after a fixed settle time and returns the result over a valid/ready handshake.
- Double-buffered: the next frame loads while the current frame settles or awaits result acceptance.

---
 rtl/mnist_frame_driver.sv | 206 ++++++++++++++++++++
 tb/tb_mnist_frame_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_driver.sv
// Binarising frame driver for the mnist_mtncl gate network.
// Pixels arrive on a valid/ready stream and are thresholded into a 49-bit
// assembly buffer. A completed frame is handed to the network between
// all-zero NULL spacers. The network output is sampled after a fixed settle
// time and returned over a valid/ready result handshake. The next frame
// assembles while the current one settles or waits for acceptance.
module mnist_frame_driver #(
    parameter int N_PIX  = 49,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic [N_PIX-1:0] net_in,
    input  logic [OUT_W-1:0] net_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_err,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    // One extra bit so a threshold equal to 2**PIX_W never truncates to zero.
    localparam logic [PIX_W:0] THRESH_V = (PIX_W + 1)'(THRESH);

    typedef enum logic [1:0] {
        P_IDLE,
        P_SETTLE,
        P_RESULT
    } pstate_t;

    pstate_t            state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [N_PIX-1:0]   abuf_reg, abuf_next;
    logic               afull_reg;
    logic               aerr_reg;
    logic               err_hold_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [N_PIX-1:0]   net_in_reg;
    logic               res_valid_reg;
    logic [OUT_W-1:0]   res_data_reg;
    logic               res_err_reg;
    logic [15:0]        frame_cnt_reg;

    logic pix_accept;
    logic pix_bit;
    logic idx_at_end;
    logic frame_done;
    logic pix_err;
    logic xfer;
    logic sample;
    logic res_take;

    assign pix_ready  = !afull_reg;
    assign pix_accept = pix_valid && !afull_reg;
    assign pix_bit    = ({1'b0, pix_data} >= THRESH_V);
    assign idx_at_end = (idx_reg == IDX_LAST);
    assign frame_done = pix_accept && (pix_last || idx_at_end);
    // A frame is well formed only when pix_last coincides with the final slot.
    assign pix_err    = (pix_last != idx_at_end);

    assign net_in    = net_in_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;
    assign frame_cnt = frame_cnt_reg;

    // Per-bit write decode: a bit loads its pixel when the write index points
    // at it and is cleared when the frame moves to the network, so an early
    // pix_last leaves the untouched tail at zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_PIX; gi++) begin : g_abuf
            assign abuf_next[gi] = xfer ? 1'b0 :
                                   (pix_accept && (idx_reg == IDX_W'(gi))) ? pix_bit :
                                   abuf_reg[gi];
        end
    endgenerate

    // Presentation state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= P_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Presentation next-state and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        xfer       = 1'b0;
        sample     = 1'b0;
        res_take   = 1'b0;
        case (state_reg)
            P_IDLE: begin
                // net_in is NULL here, so every frame gets at least one spacer cycle.
                if (afull_reg) begin
                    xfer       = 1'b1;
                    state_next = P_SETTLE;
                end
            end
            P_SETTLE: begin
                if (cnt_reg == '0) begin
                    sample     = 1'b1;
                    state_next = P_RESULT;
                end
            end
            P_RESULT: begin
                if (res_valid_reg && res_ready) begin
                    res_take   = 1'b1;
                    state_next = P_IDLE;
                end
            end
            default: state_next = P_IDLE;
        endcase
    end

    // Assembly bookkeeping: write index, frame-full flag and framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            afull_reg <= 1'b0;
            aerr_reg  <= 1'b0;
        end else if (xfer) begin
            idx_reg   <= '0;
            afull_reg <= 1'b0;
            aerr_reg  <= 1'b0;
        end else if (pix_accept) begin
            aerr_reg <= aerr_reg | pix_err;
            if (frame_done) begin
                afull_reg <= 1'b1;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Assembly buffer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abuf_reg <= '0;
        end else begin
            abuf_reg <= abuf_next;
        end
    end

    // Network drive: load on transfer, return to NULL on result acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_in_reg   <= '0;
            err_hold_reg <= 1'b0;
        end else if (xfer) begin
            net_in_reg   <= abuf_reg;
            err_hold_reg <= aerr_reg;
        end else if (res_take) begin
            net_in_reg   <= '0;
        end
    end

    // Settle countdown; reaching zero triggers the sample on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (xfer) begin
            cnt_reg <= CNT_INIT;
        end else if ((state_reg == P_SETTLE) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Result capture and handshake; data and error hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
        end else if (sample) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= net_out;
            res_err_reg   <= err_hold_reg;
        end else if (res_take) begin
            res_valid_reg <= 1'b0;
        end
    end

    // Count of accepted results, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (res_take) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_mnist_frame_driver.sv
// Self-checking bench for mnist_frame_driver: directed scenarios plus a
// randomized stream, all checked against an event-level reference model.
module tb_mnist_frame_driver;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_last = 1'b0;
    logic [48:0] net_in;
    logic [1:0]  net_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_data;
    logic        res_err;
    logic [15:0] frame_cnt;

    mnist_frame_driver #(
        .N_PIX(49), .PIX_W(8), .THRESH(128), .OUT_W(2), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last),
        .net_in(net_in), .net_out(net_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    // Network stand-in: either a tied constant, or a function of net_in seen
    // through one register stage so an early sample returns stale data.
    logic        net_mode = 1'b0;
    logic [1:0]  net_const = 2'b10;
    logic [48:0] net_d1 = '0;

    function automatic logic [1:0] fnet(input logic [48:0] x);
        return {^x, |x[48:25]};
    endfunction

    always @(posedge clk) net_d1 <= net_in;
    assign net_out = net_mode ? fnet(net_d1) : net_const;

    // Pixel stimulus queue.
    typedef struct {
        logic [7:0] data;
        logic       last;
    } pix_t;
    pix_t pq[$];

    int valid_pct = 100;
    int ready_pct = 100;

    // Reference model state.
    int          a_n;
    logic [48:0] a_bits;
    logic        a_err;
    logic        pend;
    logic [48:0] pend_bits;
    logic        pend_err;
    logic        busy;
    logic [48:0] pres_bits;
    logic        pres_err;
    logic [1:0]  pres_data;
    int          valid_from;
    int          idle_edge;
    int          last_edge;
    int          takes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        a_n = 0; a_bits = '0; a_err = 1'b0;
        pend = 1'b0; pend_bits = '0; pend_err = 1'b0;
        busy = 1'b0; pres_bits = '0; pres_err = 1'b0; pres_data = '0;
        valid_from = 0; idle_edge = -1; last_edge = -1; takes = 0;
    endtask

    function automatic logic m_valid();
        return busy && (last_edge >= valid_from);
    endfunction

    task automatic model_pixel(input logic [7:0] d, input logic l);
        a_bits[a_n] = (d >= 8'd128);
        a_err = a_err | (l != (a_n == 48));
        a_n++;
        if (l || a_n == 49) begin
            pend = 1'b1;
            pend_bits = a_bits;
            pend_err = a_err;
            a_bits = '0;
            a_err = 1'b0;
            a_n = 0;
        end
    endtask

    task automatic push_pix(input logic [7:0] d, input logic l);
        pix_t p;
        p.data = d;
        p.last = l;
        pq.push_back(p);
    endtask

    // mode: 0 random, 1 all 200, 2 alternating 127/128, 3 all 255, 4 all 0
    task automatic push_frame(input int len, input bit with_last, input int mode,
                              output logic [48:0] bits);
        logic [7:0] d;
        bits = '0;
        for (int i = 0; i < len; i++) begin
            case (mode)
                1: d = 8'd200;
                2: d = (i % 2 == 1) ? 8'd128 : 8'd127;
                3: d = 8'd255;
                4: d = 8'd0;
                default: d = 8'($urandom);
            endcase
            if (i < 49) bits[i] = (d >= 8'd128);
            push_pix(d, with_last && (i == len - 1));
        end
    endtask

    // One clock: drive, check the model's view before the edge, advance model.
    task automatic cycle();
        logic acc, tk, ev;
        int   k;
        if (pq.size() > 0 && $urandom_range(99) < valid_pct) begin
            pix_valid = 1'b1;
            pix_data  = pq[0].data;
            pix_last  = pq[0].last;
        end else begin
            pix_valid = 1'b0;
            pix_data  = 8'($urandom);
            pix_last  = 1'($urandom);
        end
        res_ready = ($urandom_range(99) < ready_pct);
        @(negedge clk);
        ev = m_valid();
        chk("pix_ready", pix_ready, !pend);
        chk("res_valid", res_valid, ev);
        chk("net_in", net_in, busy ? pres_bits : 49'd0);
        chk("frame_cnt", frame_cnt, takes[15:0]);
        if (ev) begin
            chk("res_data", res_data, pres_data);
            chk("res_err", res_err, pres_err);
        end
        acc = pix_valid && !pend;
        tk  = ev && res_ready;
        k   = last_edge + 1;
        if (tk) begin
            busy = 1'b0;
            idle_edge = k;
            takes++;
            $display("result %0d: data=%b err=%0d bits=%h", takes, pres_data, pres_err, pres_bits);
        end else if (!busy && pend && k > idle_edge) begin
            busy = 1'b1;
            pres_bits = pend_bits;
            pres_err = pend_err;
            pres_data = net_mode ? fnet(pend_bits) : net_const;
            pend = 1'b0;
            valid_from = k + SETTLE;
        end
        if (acc) begin
            model_pixel(pq[0].data, pq[0].last);
            void'(pq.pop_front());
        end
        last_edge = k;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!m_valid() && n < 400) begin
            cycle();
            n++;
        end
        chk({tag, "_arrive"}, res_valid, 1);
    endtask

    task automatic take_result();
        ready_pct = 100;
        cycle();
        ready_pct = 0;
    endtask

    task automatic do_reset(input string tag);
        pix_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_net_in"}, net_in, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_err"}, res_err, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_pix_ready"}, pix_ready, 1);
        pq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        logic [48:0] bits_a, bits_b, bits_x;
        logic        drained;
        int          n, kind;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset("init");

        // Back-to-back latency with a tied network output.
        net_mode = 1'b0;
        net_const = 2'b10;
        valid_pct = 100;
        ready_pct = 100;
        push_frame(49, 1, 1, bits_a);
        repeat (50) cycle();
        chk("lat_net_in", net_in, 49'h1_FFFF_FFFF_FFFF);
        chk("lat_pre_valid", res_valid, 0);
        repeat (2) cycle();
        chk("lat_res_valid", res_valid, 1);
        chk("lat_res_data", res_data, 2'b10);
        chk("lat_res_err", res_err, 0);
        cycle();
        chk("lat_pulse_end", res_valid, 0);
        chk("lat_frame_cnt", frame_cnt, 1);
        chk("lat_null", net_in, 0);

        // Threshold boundary with alternating 127/128.
        net_mode = 1'b1;
        ready_pct = 0;
        push_frame(49, 1, 2, bits_a);
        wait_result("alt");
        chk("alt_bit0", net_in[0], 0);
        chk("alt_bit1", net_in[1], 1);
        chk("alt_bit48", net_in[48], 0);
        take_result();

        // Early pix_last on pixel 9, then a well-formed frame.
        push_frame(10, 1, 3, bits_a);
        wait_result("early");
        chk("early_net_in", net_in, 49'h3FF);
        chk("early_err", res_err, 1);
        take_result();
        push_frame(49, 1, 0, bits_a);
        wait_result("after_early");
        chk("after_early_err", res_err, 0);
        take_result();

        // 49 pixels without pix_last; pixel 49 opens the next frame.
        push_frame(49, 0, 4, bits_a);
        push_frame(49, 1, 3, bits_b);
        wait_result("nolast");
        chk("nolast_err", res_err, 1);
        chk("nolast_net_in", net_in, 0);
        take_result();
        wait_result("nolast_next");
        chk("nolast_next_err", res_err, 0);
        chk("nolast_next_net_in", net_in, 49'h1_FFFF_FFFF_FFFF);
        take_result();

        // Result held off while the next frame fills the buffer.
        push_frame(49, 1, 0, bits_a);
        push_frame(49, 1, 0, bits_b);
        wait_result("hold");
        repeat (100) cycle();
        chk("hold_pix_ready", pix_ready, 0);
        chk("hold_net_in", net_in, bits_a);
        chk("hold_res_valid", res_valid, 1);
        ready_pct = 100;
        cycle();
        chk("hold_null_gap", net_in, 0);
        chk("hold_gap_valid", res_valid, 0);
        cycle();
        chk("hold_b_xfer", net_in, bits_b);
        wait_result("hold_b");
        take_result();

        // Reset mid-frame, then mid-result.
        ready_pct = 100;
        push_frame(49, 1, 0, bits_a);
        repeat (20) cycle();
        do_reset("rst_frame");
        ready_pct = 0;
        push_frame(49, 1, 0, bits_a);
        wait_result("rst_pre");
        do_reset("rst_result");
        push_frame(49, 1, 3, bits_a);
        wait_result("post_rst");
        chk("post_rst_cnt0", frame_cnt, 0);
        chk("post_rst_net_in", net_in, 49'h1_FFFF_FFFF_FFFF);
        chk("post_rst_data", res_data, fnet(49'h1_FFFF_FFFF_FFFF));
        take_result();
        chk("post_rst_cnt1", frame_cnt, 1);

        // Randomized stream with random backpressure on both sides.
        valid_pct = 70;
        ready_pct = 60;
        for (int f = 0; f < 12; f++) begin
            kind = $urandom_range(0, 5);
            if (kind == 4) push_frame($urandom_range(1, 48), 1, 0, bits_x);
            else if (kind == 5) push_frame(49, 0, 0, bits_x);
            else push_frame(49, 1, 0, bits_x);
        end
        push_frame(49, 1, 0, bits_x);
        n = 0;
        drained = 1'b0;
        while (!drained && n < 8000) begin
            cycle();
            n++;
            drained = (pq.size() == 0) && !pend && !busy && (a_n == 0);
        end
        chk("rand_drained_net_in", net_in, 0);
        chk("rand_drained_valid", res_valid, 0);
        chk("rand_drained_cnt", frame_cnt, takes[15:0]);
        chk("rand_drain_in_time", pix_ready && drained, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
